// File: rtl/bp_ghr_ctrl.sv
// Global-history controller for a gshare predictor: speculative/architectural GHR,
// in-flight branch queue, counter-table update port and mispredict history repair.
module bp_ghr_ctrl #(
  parameter int unsigned GHR_WIDTH   = 8,
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter int unsigned PC_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 predict_valid,
  input  logic [PC_WIDTH-1:0]  predict_pc,
  input  logic                 is_taken_in,
  output logic                 predict_ready,
  output logic [GHR_WIDTH-1:0] index,
  input  logic                 resolve_valid,
  input  logic                 resolve_taken,
  input  logic                 flush,
  output logic                 is_last_branch,
  output logic                 is_last_taken,
  output logic [GHR_WIDTH-1:0] last_index,
  output logic                 mispredict
);

  localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);
  localparam logic [PtrW:0] CntFull = (PtrW+1)'(QUEUE_DEPTH);

  logic [GHR_WIDTH-1:0]   spec_ghr_q, spec_ghr_d;
  logic [GHR_WIDTH-1:0]   arch_ghr_q, arch_ghr_d;
  logic [GHR_WIDTH-1:0]   q_index_q [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0] q_pred_q;
  logic [PtrW-1:0]        head_q, tail_q;
  logic [PtrW:0]          count_q;
  logic                   push, pop, mis, clear;
  logic                   unused_pc;

  assign unused_pc = ^{predict_pc[PC_WIDTH-1:GHR_WIDTH+2], predict_pc[1:0]};

  assign predict_ready = (count_q != CntFull);
  assign index         = spec_ghr_q ^ predict_pc[GHR_WIDTH+1:2];
  assign push          = predict_valid && predict_ready;
  assign pop           = resolve_valid && (count_q != '0);
  assign mis           = pop && (resolve_taken != q_pred_q[head_q]);
  assign clear         = flush || mis;

  // Flush and mispredict both restore from the post-resolve architectural history.
  always_comb begin
    arch_ghr_d = arch_ghr_q;
    if (pop) arch_ghr_d = {arch_ghr_q[GHR_WIDTH-2:0], resolve_taken};
    spec_ghr_d = spec_ghr_q;
    if (clear) begin
      spec_ghr_d = arch_ghr_d;
    end else if (push) begin
      spec_ghr_d = {spec_ghr_q[GHR_WIDTH-2:0], is_taken_in};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spec_ghr_q <= '0;
      arch_ghr_q <= '0;
    end else begin
      spec_ghr_q <= spec_ghr_d;
      arch_ghr_q <= arch_ghr_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) q_index_q[i] <= '0;
      q_pred_q <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
    end else if (clear) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        q_index_q[tail_q] <= index;
        q_pred_q[tail_q]  <= is_taken_in;
        tail_q            <= tail_q + PtrW'(1);
      end
      if (pop) head_q <= head_q + PtrW'(1);
      count_q <= count_q + (PtrW+1)'(push) - (PtrW+1)'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_last_branch <= 1'b0;
      is_last_taken  <= 1'b0;
      last_index     <= '0;
      mispredict     <= 1'b0;
    end else begin
      is_last_branch <= pop;
      is_last_taken  <= pop && resolve_taken;
      last_index     <= pop ? q_index_q[head_q] : '0;
      mispredict     <= mis;
    end
  end

endmodule

// File: tb/tb_bp_ghr_ctrl.sv
// Self-checking bench for bp_ghr_ctrl: queue-based reference model checked every
// negedge, plus directed scenarios with literal expectations.
module tb_bp_ghr_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        predict_valid = 1'b0;
  logic [31:0] predict_pc = '0;
  logic        is_taken_in = 1'b0;
  logic        predict_ready;
  logic [7:0]  index;
  logic        resolve_valid = 1'b0;
  logic        resolve_taken = 1'b0;
  logic        flush = 1'b0;
  logic        is_last_branch;
  logic        is_last_taken;
  logic [7:0]  last_index;
  logic        mispredict;

  int checks = 0;
  int failures = 0;

  bp_ghr_ctrl #(.GHR_WIDTH(8), .QUEUE_DEPTH(4), .PC_WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .predict_valid  (predict_valid),
    .predict_pc     (predict_pc),
    .is_taken_in    (is_taken_in),
    .predict_ready  (predict_ready),
    .index          (index),
    .resolve_valid  (resolve_valid),
    .resolve_taken  (resolve_taken),
    .flush          (flush),
    .is_last_branch (is_last_branch),
    .is_last_taken  (is_last_taken),
    .last_index     (last_index),
    .mispredict     (mispredict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: history as integers, in-flight branches as a FIFO of (index, pred).
  logic [7:0] m_spec, m_arch;
  logic [7:0] m_idx [$];
  logic       m_pred [$];
  logic       e_lb, e_lt, e_mp;
  logic [7:0] e_li;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_spec = 8'h00;
      m_arch = 8'h00;
      m_idx.delete();
      m_pred.delete();
      e_lb = 1'b0; e_lt = 1'b0; e_mp = 1'b0; e_li = 8'h00;
    end else begin
      logic       can_push;
      logic [7:0] cur_idx;
      can_push = m_idx.size() < 4;
      cur_idx  = m_spec ^ predict_pc[9:2];
      e_lb = 1'b0; e_mp = 1'b0;
      if (resolve_valid && m_idx.size() > 0) begin
        e_lb = 1'b1;
        e_lt = resolve_taken;
        e_li = m_idx.pop_front();
        e_mp = (m_pred.pop_front() != resolve_taken);
        m_arch = (m_arch << 1) | 8'(resolve_taken);
      end
      if (flush || e_mp) begin
        m_spec = m_arch;
        m_idx.delete();
        m_pred.delete();
      end else if (predict_valid && can_push) begin
        m_idx.push_back(cur_idx);
        m_pred.push_back(is_taken_in);
        m_spec = (m_spec << 1) | 8'(is_taken_in);
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("m_ready", 32'(predict_ready), 32'(m_idx.size() < 4));
      chk("m_index", 32'(index), 32'(m_spec ^ predict_pc[9:2]));
      chk("m_last_branch", 32'(is_last_branch), 32'(e_lb));
      chk("m_mispredict", 32'(mispredict), 32'(e_mp));
      if (e_lb) begin
        chk("m_last_taken", 32'(is_last_taken), 32'(e_lt));
        chk("m_last_index", 32'(last_index), 32'(e_li));
      end
    end
  end

  task automatic drive(input logic pv, input logic [31:0] pc, input logic tk,
                       input logic rv, input logic rt, input logic fl);
    predict_valid = pv; predict_pc = pc; is_taken_in = tk;
    resolve_valid = rv; resolve_taken = rt; flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    chk("rst_ready", 32'(predict_ready), 32'd1);
    chk("rst_index", 32'(index), 32'h00);
    chk("rst_last_branch", 32'(is_last_branch), 32'd0);
    chk("rst_last_index", 32'(last_index), 32'h00);
    chk("rst_mispredict", 32'(mispredict), 32'd0);
    rst = 1'b1;

    // First push and history shift.
    drive(1, 32'h10, 1, 0, 0, 0);
    #1 chk("push_index", 32'(index), 32'h04);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1 chk("spec_after_push", 32'(index), 32'h01);

    // Fill to full; the fifth push is dropped.
    drive(1, 0, 0, 0, 0, 0);
    repeat (3) tick();
    drive(1, 0, 1, 0, 0, 0);
    #1 chk("full_ready", 32'(predict_ready), 32'd0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1 chk("full_spec_hold", 32'(index), 32'h08);

    // Correct resolves drain the queue in order.
    drive(0, 0, 0, 1, 1, 0);
    tick();
    chk("res1_lb", 32'(is_last_branch), 32'd1);
    chk("res1_lt", 32'(is_last_taken), 32'd1);
    chk("res1_li", 32'(last_index), 32'h04);
    chk("res1_mp", 32'(mispredict), 32'd0);
    drive(0, 0, 0, 1, 0, 0);
    tick();
    chk("res2_li", 32'(last_index), 32'h01);
    repeat (2) tick();
    chk("res4_li", 32'(last_index), 32'h04);
    drive(0, 0, 0, 1, 1, 0);
    tick();
    chk("empty_res_lb", 32'(is_last_branch), 32'd0);
    drive(0, 0, 0, 0, 0, 0);
    #1 chk("empty_res_spec", 32'(index), 32'h08);

    // Asynchronous reset mid-stream.
    drive(1, 32'h40, 1, 0, 0, 0);
    #1 chk("pc_index", 32'(index), 32'h18);
    tick();
    drive(0, 0, 0, 1, 1, 0);
    tick();
    chk("pre_rst_lb", 32'(is_last_branch), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_lb", 32'(is_last_branch), 32'd0);
    chk("async_li", 32'(last_index), 32'h00);
    chk("async_index", 32'(index), 32'h00);
    chk("async_ready", 32'(predict_ready), 32'd1);
    drive(0, 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    tick();

    // Mispredict: preds 1,1,0 then resolve first as not-taken with a concurrent push.
    drive(1, 0, 1, 0, 0, 0);
    repeat (2) tick();
    drive(1, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1 chk("mis_pre_spec", 32'(index), 32'h06);
    drive(1, 0, 1, 1, 0, 0);
    tick();
    chk("mis_mp", 32'(mispredict), 32'd1);
    chk("mis_lb", 32'(is_last_branch), 32'd1);
    chk("mis_lt", 32'(is_last_taken), 32'd0);
    chk("mis_li", 32'(last_index), 32'h00);
    drive(0, 0, 0, 0, 0, 0);
    #1 chk("mis_spec", 32'(index), 32'h00);
    drive(0, 0, 0, 1, 1, 0);
    tick();
    chk("mis_cleared", 32'(is_last_branch), 32'd0);

    // Flush with a simultaneous correct resolve and push.
    drive(1, 0, 1, 0, 0, 0);
    repeat (2) tick();
    drive(1, 0, 0, 1, 1, 1);
    tick();
    chk("flush_lb", 32'(is_last_branch), 32'd1);
    chk("flush_mp", 32'(mispredict), 32'd0);
    chk("flush_li", 32'(last_index), 32'h00);
    drive(0, 32'h10, 0, 1, 0, 0);
    #1 chk("flush_spec", 32'(index), 32'h05);
    tick();
    chk("flush_cleared", 32'(is_last_branch), 32'd0);

    // Mixed traffic including simultaneous push/pop, checked by the model.
    for (int i = 0; i < 48; i++) begin
      logic [5:0] b;
      b = 6'(i);
      drive(i % 3 != 2, 32'(i * 28 + 4), b[0] ^ b[2], b[0] | b[3], b[1] ^ b[4], i == 25);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bp_ghr_ctrl.md
# bp_ghr_ctrl

Global-history controller for the gshare branch predictor. It keeps a speculative and an architectural global history register (GHR) and forms the counter-table index as the fetch PC XOR the speculative GHR. It queues the index and prediction of every in-flight branch. When ID resolves a branch, it drives the update port (`is_last_branch`, `is_last_taken`, `last_index`) of the pattern history table and repairs the history on a mispredict.

## Interface
Parameters:
- `GHR_WIDTH`, 8, history and index width; the counter table has 2^GHR_WIDTH entries.
- `QUEUE_DEPTH`, 4, number of unresolved branches tracked; must be a power of 2 and at least 2.
- `PC_WIDTH`, 32, fetch PC width.

Ports:
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `predict_valid`  in  1  IF presents a branch needing a prediction this cycle.
- `predict_pc`  in  PC_WIDTH  PC of that branch.
- `is_taken_in`  in  1  counter-table prediction for `index`, returned in the same cycle.
- `predict_ready`  out  1  queue can accept a branch (combinational, `!full`).
- `index`  out  GHR_WIDTH  lookup index (combinational).
- `resolve_valid`  in  1  ID resolves the oldest in-flight branch.
- `resolve_taken`  in  1  actual direction.
- `flush`  in  1  pipeline flush (exception/eret); discards all in-flight branches.
- `is_last_branch`  out  1  update strobe to the counter table (registered).
- `is_last_taken`  out  1  update direction (registered).
- `last_index`  out  GHR_WIDTH  update index (registered).
- `mispredict`  out  1  one-cycle pulse: resolved direction differed from the queued prediction (registered).

## Operation
- `index = spec_ghr ^ predict_pc[GHR_WIDTH+1:2]`.
- Push on `predict_valid && predict_ready`:
  - enqueue {index, is_taken_in};
  - `spec_ghr <= {spec_ghr[GHR_WIDTH-2:0], is_taken_in}`.
- Pop on `resolve_valid && !empty`:
  - dequeue the head;
  - `arch_ghr <= {arch_ghr[GHR_WIDTH-2:0], resolve_taken}`;
  - next cycle `is_last_branch=1`, `is_last_taken=resolve_taken`, `last_index=head.index`, `mispredict=(resolve_taken != head.pred)`.
- Mispredict recovery happens in the same edge as the pop:
  - `spec_ghr <= {arch_ghr[GHR_WIDTH-2:0], resolve_taken}`;
  - the queue is cleared (all younger entries dropped);
  - any simultaneous push is discarded.
- `resolve_valid` on an empty queue is ignored: no outputs and no GHR change.
- Flush:
  - `spec_ghr <= arch_ghr`, queue cleared, simultaneous push discarded.
  - A simultaneous resolve is still performed first. It updates `arch_ghr` and drives the update outputs, and `spec_ghr` takes the post-resolve `arch_ghr` value.
  - Flush has priority over mispredict recovery for `spec_ghr`. Both yield the same value.
- Full queue: `predict_ready=0`, the push is dropped and `spec_ghr` is unchanged. A pop in the same cycle does not make `predict_ready` high in that cycle.
- Queue: circular buffer with head/tail pointers of log2(QUEUE_DEPTH) bits that wrap modulo depth, plus a count of log2(QUEUE_DEPTH)+1 bits.
  - Push and pop in the same cycle leave the count unchanged.

## Timing
- Reset (async assert, on `rst` low):
  - both GHRs, the queue, pointers and count are 0;
  - `is_last_branch=0`, `is_last_taken=0`, `last_index=0`, `mispredict=0`;
  - `predict_ready=1`.
  - Reset mid-operation discards all in-flight state immediately.
- `index` and `predict_ready` are combinational. The `spec_ghr` effect of a push is visible in `index` the next cycle.
- Update outputs and `mispredict` are valid exactly one cycle after the resolve edge and are high for one cycle per resolve.
- Back-to-back pushes at 1/cycle and back-to-back resolves at 1/cycle are sustained.

## Test plan
- Reset, then `predict_pc=0x0000_0010`, `is_taken_in=1` → `index=0x04`; next cycle `spec_ghr=0x01`, count=1.
- Push 4 branches with no resolve → `predict_ready=0`. A 5th `predict_valid` is dropped and `spec_ghr` is unchanged.
- Push pred=1 at index 0x04, then resolve taken=1 → next cycle `is_last_branch=1`, `is_last_taken=1`, `last_index=0x04`, `mispredict=0`, `arch_ghr=0x01`.
- Push preds 1,1,0 from `arch_ghr=0`, then resolve the first as taken=0 → `mispredict=1`, `spec_ghr=0x00`, queue empty, `arch_ghr=0x00`.
- With 2 in flight, assert `flush` together with a correct resolve (taken=1) → one update pulse, `arch_ghr=0x01`, `spec_ghr=0x01`, count=0.
- Resolve on empty queue → no `is_last_branch` pulse and no GHR change.
- Assert `rst` mid-stream, asynchronous to `clk` → outputs zero before the next edge.
